if_fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of the IF/ID pipeline register. Holds the PC and issues in-order word fetches to instruction memory over a valid/ready request channel. Buffers returned instructions in a small FIFO and presents {nextPC, instruction} as bits [0:63] of the IF/ID bundle. The combinational decoder appends control bits [64:82] downstream. Handles downstream stall and branch/jump redirect, including discarding stale in-flight responses.

---
 rtl/if_fetch_stage.sv | 165 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, credit-limited in-order word fetch, fetch FIFO and redirect flush.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [0:31] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [0:31] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] out_bundle
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [0:31] perf_fetched,
  output logic [0:31] perf_dropped
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  logic [0:31]   r_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic          r_out_valid;
  logic [0:63]   r_fifo [DEPTH];
  logic [0:31]   r_aq   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_aq_wr;
  logic [AW-1:0] r_aq_rd;

  logic [CW+1:0] w_credit_sum;
  logic          w_req_valid;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_rsp_drop;
  logic [CW:0]   w_inflight;
  logic [CW:0]   w_drop_acc;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_outstanding_nxt;
  logic [CW-1:0] w_drop_nxt;

  // Every buffered word, live request and stale request holds one credit.
  assign w_credit_sum = (CW+2)'(r_count) + (CW+2)'(r_outstanding) + (CW+2)'(r_drop);
  assign w_req_valid  = rst_n & ~redirect_valid & (w_credit_sum < DEPTH_W);
  assign w_issue      = w_req_valid & imem_req_ready;
  assign w_rsp_drop   = imem_rsp_valid & (r_drop != {CW{1'b0}});
  assign w_push       = imem_rsp_valid & (r_drop == {CW{1'b0}}) & ~redirect_valid;
  assign w_pop        = r_out_valid & out_ready & ~redirect_valid;
  assign w_inflight   = (CW+1)'(r_drop) + (CW+1)'(r_outstanding);
  assign w_drop_acc   = w_inflight - (CW+1)'(imem_rsp_valid);

  // Next-state for the occupancy counters; a redirect turns all in-flight work into drops.
  always_comb begin
    w_count_nxt       = r_count;
    w_outstanding_nxt = r_outstanding;
    w_drop_nxt        = r_drop;
    if (redirect_valid) begin
      w_count_nxt       = {CW{1'b0}};
      w_outstanding_nxt = {CW{1'b0}};
      if (w_inflight == {(CW+1){1'b0}}) begin
        w_drop_nxt = {CW{1'b0}};
      end else if (w_drop_acc > DEPTH_X) begin
        w_drop_nxt = DEPTH_C;
      end else begin
        w_drop_nxt = CW'(w_drop_acc);
      end
    end else begin
      w_count_nxt       = r_count + CW'(w_push) - CW'(w_pop);
      w_outstanding_nxt = r_outstanding + CW'(w_issue) - CW'(w_push);
      w_drop_nxt        = r_drop - CW'(w_rsp_drop);
    end
  end

  // PC, address queue, fetch FIFO and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_count       <= {CW{1'b0}};
      r_outstanding <= {CW{1'b0}};
      r_drop        <= {CW{1'b0}};
      r_out_valid   <= 1'b0;
      r_wr_ptr      <= {AW{1'b0}};
      r_rd_ptr      <= {AW{1'b0}};
      r_aq_wr       <= {AW{1'b0}};
      r_aq_rd       <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= 64'h0;
        r_aq[i]   <= 32'h0;
      end
    end else begin
      r_count       <= w_count_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop        <= w_drop_nxt;
      r_out_valid   <= (w_count_nxt != {CW{1'b0}});
      if (redirect_valid) begin
        r_pc     <= redirect_pc & 32'hFFFF_FFFC;
        r_wr_ptr <= {AW{1'b0}};
        r_rd_ptr <= {AW{1'b0}};
        r_aq_wr  <= {AW{1'b0}};
        r_aq_rd  <= {AW{1'b0}};
      end else begin
        if (w_issue) begin
          r_pc          <= r_pc + 32'd4;
          r_aq[r_aq_wr] <= r_pc;
          r_aq_wr       <= r_aq_wr + PTR_ONE;
        end
        // Response pairs with the oldest live request address.
        if (w_push) begin
          r_fifo[r_wr_ptr] <= {r_aq[r_aq_rd] + 32'd4, imem_rsp_data};
          r_wr_ptr         <= r_wr_ptr + PTR_ONE;
          r_aq_rd          <= r_aq_rd + PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
      end
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign out_valid      = rst_n & r_out_valid;
  assign out_bundle     = rst_n ? r_fifo[r_rd_ptr] : 64'h0;

`ifdef FETCH_PERF_CNT_EN
  logic [0:31] r_perf_fetched;
  logic [0:31] r_perf_dropped;
  logic        w_rsp_discard;

  assign w_rsp_discard = imem_rsp_valid & (redirect_valid | (r_drop != {CW{1'b0}}));

  // Accepted pops, plus every discarded response and flushed FIFO entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'h0;
      r_perf_dropped <= 32'h0;
    end else begin
      r_perf_fetched <= r_perf_fetched + 32'(w_pop);
      r_perf_dropped <= r_perf_dropped + 32'(w_rsp_discard)
                        + (redirect_valid ? 32'(r_count) : 32'h0);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
`endif

  credit_bound_a: assert property (@(posedge clk) disable iff (!rst_n) w_credit_sum <= DEPTH_W);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised bench for if_fetch_stage: memory model plus a transaction-level queue model
// of fetched addresses and the bundles the stage should present.
module tb_if_fetch_stage;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, out_valid, out_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc;
  logic [63:0] out_bundle;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_bundle(out_bundle)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
    bit          stale;
  } req_t;

  req_t        pend_q[$];   // requests accepted by memory, not yet answered
  logic [63:0] buf_q[$];    // bundles the stage should be holding, oldest first
  logic [31:0] exp_pc;
  int          cyc, lat_min, lat_max;
  int          checks, errors;
  bit          redir_on_rsp;
  logic        s_req_valid, s_out_valid, s_rsp, s_redir;
  logic [31:0] s_addr;
  logic [63:0] s_bundle;
  logic        e_req_valid, e_out_valid;
  logic [31:0] e_addr;
  logic [63:0] e_bundle;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // One clock: drive memory response, sample DUT and model expectations, then advance the model.
  task automatic tick();
    req_t p;
    bit   pop;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (rst_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_q[0].data;
    end
    if (redir_on_rsp && imem_rsp_valid && buf_q.size() > 0) begin
      redirect_valid = 1'b1;
      redir_on_rsp   = 1'b0;
    end
    #1;
    e_req_valid = rst_n && !redirect_valid && (pend_q.size() + buf_q.size() < DEPTH);
    e_out_valid = rst_n && (buf_q.size() > 0);
    e_bundle    = e_out_valid ? buf_q[0] : 64'h0;
    e_addr      = exp_pc;
    s_req_valid = imem_req_valid;
    s_out_valid = out_valid;
    s_addr      = imem_req_addr;
    s_bundle    = out_bundle;
    s_rsp       = imem_rsp_valid;
    s_redir     = redirect_valid;
    @(posedge clk);
    #1;
    pop = e_out_valid && out_ready && !redirect_valid;
    if (!rst_n) begin
      pend_q.delete();
      buf_q.delete();
      exp_pc = RPC;
    end else begin
      if (pop) void'(buf_q.pop_front());
      if (imem_rsp_valid) begin
        p = pend_q.pop_front();
        if (!p.stale && !redirect_valid) buf_q.push_back({p.addr + 32'd4, p.data});
      end
      if (redirect_valid) begin
        buf_q.delete();
        foreach (pend_q[i]) pend_q[i].stale = 1'b1;
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (e_req_valid && imem_req_ready) begin
        p.addr  = exp_pc;
        p.data  = mem_word(exp_pc);
        p.due   = cyc + int'($urandom_range(lat_max, lat_min));
        p.stale = 1'b0;
        pend_q.push_back(p);
        exp_pc  = exp_pc + 32'd4;
      end
    end
    redirect_valid = 1'b0;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (s_req_valid !== 1'b0 || s_out_valid !== 1'b0 || s_bundle !== 64'h0) begin
        errors++;
        $display("FAIL reset_outputs got req_valid=%b out_valid=%b bundle=%h want 0 0 0",
                 s_req_valid, s_out_valid, s_bundle);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream_wrap();
    logic [31:0] addrs[$];
    logic [63:0] got[$];
    logic [31:0] want_a [3];
    logic [63:0] want_b [3];
    int t_iss, t_val;
    want_a[0] = 32'hFFFF_FFF8; want_a[1] = 32'hFFFF_FFFC; want_a[2] = 32'h0000_0000;
    want_b[0] = {32'hFFFF_FFFC, mem_word(32'hFFFF_FFF8)};
    want_b[1] = {32'h0000_0000, mem_word(32'hFFFF_FFFC)};
    want_b[2] = {32'h0000_0004, mem_word(32'h0000_0000)};
    lat_min = 1; lat_max = 1; t_iss = -1; t_val = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if (s_req_valid !== e_req_valid) begin
        errors++;
        $display("FAIL stream_req_valid cyc=%0d got %b want %b", i, s_req_valid, e_req_valid);
      end
      if (s_req_valid === 1'b1) addrs.push_back(s_addr);
      if (t_iss < 0 && s_req_valid === 1'b1) t_iss = i;
      if (t_val < 0 && s_out_valid === 1'b1) t_val = i;
      if (s_out_valid === 1'b1) got.push_back(s_bundle);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (addrs.size() <= k || addrs[k] !== want_a[k]) begin
        errors++;
        $display("FAIL wrap_addr[%0d] got %h want %h", k, (addrs.size() > k) ? addrs[k] : 32'hx, want_a[k]);
      end
      checks++;
      if (got.size() <= k || got[k] !== want_b[k]) begin
        errors++;
        $display("FAIL wrap_bundle[%0d] got %h want %h", k, (got.size() > k) ? got[k] : 64'hx, want_b[k]);
      end
    end
    checks++;
    if (t_iss < 0 || t_val - t_iss != 2) begin
      errors++;
      $display("FAIL first_valid_latency got %0d cycles want 2", t_val - t_iss);
    end
  endtask

  task automatic test_stall();
    logic [63:0] held;
    bit have;
    int n;
    out_ready = 1'b0; have = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (s_out_valid !== e_out_valid || (e_out_valid && s_bundle !== e_bundle)) begin
        errors++;
        $display("FAIL stall_bundle got %b/%h want %b/%h", s_out_valid, s_bundle, e_out_valid, e_bundle);
      end
      if (have) begin
        checks++;
        if (s_bundle !== held) begin
          errors++;
          $display("FAIL stall_hold got %h want %h", s_bundle, held);
        end
      end else if (s_out_valid === 1'b1) begin
        held = s_bundle; have = 1'b1;
      end
    end
    checks++;
    if (s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_request got %b want 0", s_req_valid);
    end
    out_ready = 1'b1; imem_req_ready = 1'b0; n = 0;
    while ((buf_q.size() > 0 || pend_q.size() > 0) && n < 20) begin
      tick();
      n++;
      checks++;
      if (s_out_valid !== e_out_valid || (e_out_valid && s_bundle !== e_bundle)) begin
        errors++;
        $display("FAIL drain_bundle got %b/%h want %b/%h", s_out_valid, s_bundle, e_out_valid, e_bundle);
      end
    end
    checks++;
    if (buf_q.size() > 0 || pend_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d left want 0", buf_q.size() + pend_q.size());
    end
  endtask

  task automatic test_redirect();
    int n;
    lat_min = 3; lat_max = 3; imem_req_ready = 1'b1; out_ready = 1'b1; n = 0;
    while (!(pend_q.size() == 2 && buf_q.size() == 0) && n < 20) begin
      tick();
      n++;
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    checks++;
    if (s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_no_issue got %b want 0", s_req_valid);
    end
    n = 0;
    do begin
      tick();
      n++;
      checks++;
      if (s_out_valid !== e_out_valid) begin
        errors++;
        $display("FAIL redirect_stale_valid got %b want %b", s_out_valid, e_out_valid);
      end
    end while (s_out_valid !== 1'b1 && n < 20);
    checks++;
    if (s_bundle !== {32'h0000_0104, mem_word(32'h0000_0100)}) begin
      errors++;
      $display("FAIL redirect_first_bundle got %h want %h", s_bundle, {32'h0000_0104, mem_word(32'h0000_0100)});
    end
  endtask

  task automatic test_redirect_coincident();
    int n;
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    redirect_pc = 32'h0000_0203; redir_on_rsp = 1'b1; n = 0;
    do begin
      tick();
      n++;
    end while (s_redir !== 1'b1 && n < 30);
    redir_on_rsp = 1'b0;
    checks++;
    if (s_redir !== 1'b1 || s_req_valid !== 1'b0 || s_out_valid !== 1'b1 || s_rsp !== 1'b1) begin
      errors++;
      $display("FAIL coincident_cycle got redir=%b req_valid=%b out_valid=%b rsp=%b want 1 0 1 1",
               s_redir, s_req_valid, s_out_valid, s_rsp);
    end
    tick();
    checks++;
    if (s_out_valid !== 1'b0 || s_addr !== 32'h0000_0200 || s_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL coincident_after got out_valid=%b addr=%h req_valid=%b want 0 00000200 1",
               s_out_valid, s_addr, s_req_valid);
    end
  endtask

  task automatic test_reset_midstream();
    int n;
    out_ready = 1'b0; imem_req_ready = 1'b1; n = 0;
    while (buf_q.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (s_req_valid !== 1'b0 || s_out_valid !== 1'b0 || s_bundle !== 64'h0) begin
      errors++;
      $display("FAIL midreset_outputs got %b %b %h want 0 0 0", s_req_valid, s_out_valid, s_bundle);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if (s_out_valid !== 1'b0 || s_req_valid !== 1'b1 || s_addr !== RPC) begin
      errors++;
      $display("FAIL midreset_restart got out_valid=%b req_valid=%b addr=%h want 0 1 %h",
               s_out_valid, s_req_valid, s_addr, RPC);
    end
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      out_ready      = ($urandom_range(9, 0) < 7);
      rst_n          = ($urandom_range(99, 0) != 0);
      if (rst_n && $urandom_range(24, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end
      tick();
      checks++;
      if (s_req_valid !== e_req_valid) begin
        errors++;
        $display("FAIL rand_req_valid cyc=%0d got %b want %b", cyc, s_req_valid, e_req_valid);
      end
      checks++;
      if (e_req_valid && s_addr !== e_addr) begin
        errors++;
        $display("FAIL rand_addr cyc=%0d got %h want %h", cyc, s_addr, e_addr);
      end
      checks++;
      if (s_out_valid !== e_out_valid) begin
        errors++;
        $display("FAIL rand_out_valid cyc=%0d got %b want %b", cyc, s_out_valid, e_out_valid);
      end
      checks++;
      if ((e_out_valid || !rst_n) && s_bundle !== e_bundle) begin
        errors++;
        $display("FAIL rand_bundle cyc=%0d got %h want %h", cyc, s_bundle, e_bundle);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    exp_pc = RPC; cyc = 0; lat_min = 1; lat_max = 1; checks = 0; errors = 0; redir_on_rsp = 1'b0;
    test_reset();
    test_stream_wrap();
    test_stall();
    test_redirect();
    test_redirect_coincident();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
